// File: rtl/class2017_pkg.sv
// Shared constants for the class2017 round-robin demux and its matching combine block.
package class2017_pkg;

  // Default data and debug-counter widths
  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_CNT_W = 8;

  // Channel indices, also the encoding of the sel output
  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

endpackage

// File: rtl/class2017_rr_demux_if.sv
// Bus bundle for the round-robin demux: one input stream, two output streams,
// the routing pointer and per-channel delivered-beat counters.
//   slave  : block side (accepts in_*, drives out*_*, sel, cnt*)
//   master : environment side (drives in_*, out*_ready)
interface class2017_rr_demux_if
  import class2017_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out0_valid;
  logic [WIDTH-1:0] out0_data;
  logic             out0_ready;
  logic             out1_valid;
  logic [WIDTH-1:0] out1_data;
  logic             out1_ready;
  logic             sel;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  modport slave (
    input  in_valid, in_data, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out1_valid, out1_data, sel, cnt0, cnt1
  );

  modport master (
    output in_valid, in_data, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out1_valid, out1_data, sel, cnt0, cnt1
  );
endinterface

// File: rtl/class2017_hold_reg.sv
// One-entry valid/data holding register with a drained-beat counter.
// Ports: clk, rst (async, active-high); load/load_data fill the entry;
// ready is the consumer accept; valid/data present the entry; cnt counts
// completed output transfers modulo 2^CNT_W.
module class2017_hold_reg
  import class2017_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] cnt
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Drain first, then load, so a same-cycle drain+fill keeps valid high
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (valid_q && ready) begin
      valid_d = 1'b0;
      cnt_d   = cnt_q + CNT_W'(1);
    end
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign cnt   = cnt_q;

endmodule

// File: rtl/class2017_rr_demux.sv
// Round-robin 1-to-2 stream demux: accepted input beats alternate strictly
// between channel 0 and channel 1, each channel buffered by a one-entry
// holding register. A full, stalled selected channel blocks the input even if
// the other channel is free, preserving strict alternation.
// Ports: clk, rst (async, active-high); bus (slave modport) carries the input
// stream, both output streams, sel (next target channel) and cnt0/cnt1.
module class2017_rr_demux
  import class2017_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  class2017_rr_demux_if.slave   bus
);

  logic sel_q, sel_d;
  logic in_ready_c;
  logic acc_c;
  logic load0_c, load1_c;

  // Ready follows only the selected channel; toggle sel on every accept
  always_comb begin
    sel_d      = sel_q;
    in_ready_c = (sel_q == CH0) ? (~bus.out0_valid | bus.out0_ready)
                                : (~bus.out1_valid | bus.out1_ready);
    acc_c      = bus.in_valid & in_ready_c;
    load0_c    = acc_c & (sel_q == CH0);
    load1_c    = acc_c & (sel_q == CH1);
    if (acc_c) begin
      sel_d = ~sel_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q <= CH0;
    end else begin
      sel_q <= sel_d;
    end
  end

  assign bus.in_ready = in_ready_c;
  assign bus.sel      = sel_q;

  class2017_hold_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_ch0 (
    .clk       (clk),
    .rst       (rst),
    .load      (load0_c),
    .load_data (bus.in_data),
    .ready     (bus.out0_ready),
    .valid     (bus.out0_valid),
    .data      (bus.out0_data),
    .cnt       (bus.cnt0)
  );

  class2017_hold_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_ch1 (
    .clk       (clk),
    .rst       (rst),
    .load      (load1_c),
    .load_data (bus.in_data),
    .ready     (bus.out1_ready),
    .valid     (bus.out1_valid),
    .data      (bus.out1_data),
    .cnt       (bus.cnt1)
  );

endmodule

// File: doc/class2017_rr_demux.md
Name: class2017_rr_demux

Overview:
- Splits one input stream into two output streams, the opposite of a 2-to-1 combine.
- Input beats go to channel 0 and channel 1 in strict alternation.
- Every port uses a valid/ready handshake, and each output channel has its own one-entry holding register.
- Sits in front of paired consumers that each take half of the traffic. Also exposes per-channel beat counters for debug.

Parameters:
- WIDTH, 8, data width of the input and of each output channel.
- CNT_W, 8, width of each per-channel beat counter; counters wrap modulo 2^CNT_W.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input beat present.
- in_data  input  WIDTH  input beat payload.
- in_ready  output  1  block accepts the input beat this cycle.
- out0_valid  output  1  channel 0 holding register full.
- out0_data  output  WIDTH  channel 0 payload.
- out0_ready  input  1  channel 0 consumer accepts.
- out1_valid  output  1  channel 1 holding register full.
- out1_data  output  WIDTH  channel 1 payload.
- out1_ready  input  1  channel 1 consumer accepts.
- sel  output  1  channel that the next accepted beat will go to.
- cnt0  output  CNT_W  number of beats delivered on channel 0.
- cnt1  output  CNT_W  number of beats delivered on channel 1.

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset rst is asynchronous and active-high.
  - While rst=1, all state clears immediately, independent of clk.
  - Reset values: out0_valid=0, out1_valid=0, out0_data=0, out1_data=0, sel=0, cnt0=0, cnt1=0.
  - in_ready after reset equals 1, because the selected register is empty.
- Handshakes:
  - Input accept: acc = in_valid & in_ready.
  - Output transfer on channel k: outk_valid & outk_ready.
- in_ready (combinational):
  - in_ready = ~outS_valid | outS_ready, where S = sel.
  - in_ready never depends on in_valid.
  - in_ready ignores the state of the channel that is not selected.
- Routing:
  - On acc, in_data is written into the channel-sel register, and that channel's valid is set at the next edge.
  - sel toggles on every acc and on nothing else.
  - Order is strict round robin: beats 0, 2, 4, … go to channel 0; beats 1, 3, 5, … go to channel 1.
  - A stalled channel blocks the input even if the other channel is free. This is a deliberate ordering guarantee; the block never skips a channel.
- Latency: exactly 1 cycle from acc to the corresponding outk_valid=1.
- Simultaneous drain and fill on the same channel in the same cycle:
  - outk_valid stays 1.
  - outk_data takes the new beat.
  - Full throughput of 1 beat/cycle is sustained when the consumers keep their ready signals high.
- Holding registers:
  - While outk_valid=1 and outk_ready=0, outk_data holds stable.
  - outk_valid never drops without a transfer.
- Counters:
  - cntk increments by 1 on every channel-k output transfer, not on input acceptance.
  - Wraps from 2^CNT_W-1 to 0 with no flag.
- in_valid=0 → no state change other than output transfers.
- Reset mid-operation:
  - Pending beats are discarded and no partial output remains.
  - After reset releases, the first accepted beat goes to channel 0.
- No X propagation: outk_data is driven from registers only.

Decomposition:
- Shared package class2017_pkg holds:
  - CH0=1'b0 and CH1=1'b1 channel index constants.
  - Default WIDTH and CNT_W localparams, reused by the matching combine block.
- One natural sub-module: class2017_hold_reg.
  - One-entry valid/data register with load and drain inputs, plus a beat counter.
  - Instantiated once per channel.
- The top level holds sel, the in_ready multiplexing and the load steering.

Test Plan:
- Reset then stream:
  - Stimulus: rst pulse; hold out0_ready=1 and out1_ready=1; send 0x11, 0x22, 0x33, 0x44 back-to-back.
  - Response: out0 delivers 0x11 then 0x33; out1 delivers 0x22 then 0x44; each appears 1 cycle after acceptance; in_ready stays 1 throughout; cnt0=2, cnt1=2.
- Stall blocks input:
  - Stimulus: out1_ready=0; send 0xA0, 0xA1, 0xA2.
  - Response: 0xA0 appears on out0; 0xA1 is held on out1; in_ready=1 for 0xA2 because channel 0 drains.
  - Stimulus continued: 0xA3 arrives.
  - Response: in_ready=0; out1_data stays 0xA1 until out1_ready=1; 0xA3 is accepted in that same cycle.
- Drain+fill same cycle:
  - Stimulus: out0_valid=1 with 0x55, out0_ready=1, sel=0, in_valid=1 with 0x66.
  - Response: next cycle out0_valid=1 and out0_data=0x66; cnt0 increments by 1.
- Counter wrap:
  - Stimulus: CNT_W=2; deliver 5 beats to channel 0.
  - Response: cnt0 reads 1,2,3,0,1.
- Async reset mid-operation:
  - Stimulus: both channels full; assert rst between clock edges.
  - Response: out0_valid, out1_valid, sel and both counters go to 0 before the next edge; the next beat after release goes to out0.
- Idle:
  - Stimulus: in_valid=0 for 10 cycles with both ready signals high.
  - Response: no valid asserted, sel unchanged, counters unchanged.
